// File: rtl/generador_pasos.sv
// Step-sequence generator: emits a paced train of single-cycle nxt pulses with a fixed dir
// so that an attached up/down counter walks from its current value to a requested target.
module generador_pasos #(
   parameter int WIDTH     = 4,
   parameter int DIV_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic                 stop,
   input  logic [WIDTH-1:0]     target,
   input  logic [DIV_WIDTH-1:0] period,
   output logic                 nxt,
   output logic                 dir,
   output logic                 enable,
   output logic [WIDTH-1:0]     posicion,
   output logic                 busy,
   output logic                 done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      PULSE = 2'd2,
      GAP   = 2'd3
   } state_t;

   state_t               state_reg, state_next;
   logic [WIDTH-1:0]     tgt_r, tgt_next;
   logic [DIV_WIDTH-1:0] per_r, per_next;
   logic [DIV_WIDTH-1:0] gap_reg, gap_next;
   logic [WIDTH-1:0]     pos_reg, pos_next;
   logic                 stop_lat_reg, stop_lat_next;
   logic                 nxt_reg, nxt_next;
   logic                 dir_reg, dir_next;
   logic                 enable_reg, enable_next;
   logic                 busy_reg, busy_next;
   logic                 done_reg, done_next;

   // stop_seen includes a stop arriving in the very last gap cycle, before it is latched
   logic stop_seen;
   assign stop_seen = stop_lat_reg | stop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         tgt_r        <= '0;
         per_r        <= '0;
         gap_reg      <= '0;
         pos_reg      <= '0;
         stop_lat_reg <= 1'b0;
         nxt_reg      <= 1'b0;
         dir_reg      <= 1'b0;
         enable_reg   <= 1'b0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         tgt_r        <= tgt_next;
         per_r        <= per_next;
         gap_reg      <= gap_next;
         pos_reg      <= pos_next;
         stop_lat_reg <= stop_lat_next;
         nxt_reg      <= nxt_next;
         dir_reg      <= dir_next;
         enable_reg   <= enable_next;
         busy_reg     <= busy_next;
         done_reg     <= done_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      tgt_next      = tgt_r;
      per_next      = per_r;
      gap_next      = gap_reg;
      pos_next      = pos_reg;
      stop_lat_next = stop_lat_reg;
      nxt_next      = 1'b0;
      dir_next      = dir_reg;
      enable_next   = enable_reg;
      busy_next     = busy_reg;
      done_next     = 1'b0;

      unique case (state_reg)
         IDLE: begin
            stop_lat_next = 1'b0;
            if (load) begin
               tgt_next = target;
               per_next = (period == '0) ? DIV_WIDTH'(1) : period;
               if (target == pos_reg) begin
                  done_next = 1'b1;
               end else begin
                  dir_next    = (target > pos_reg);
                  enable_next = 1'b1;
                  busy_next   = 1'b1;
                  state_next  = SETUP;
               end
            end
         end

         SETUP: begin
            stop_lat_next = stop_seen;
            nxt_next      = 1'b1;
            state_next    = PULSE;
         end

         PULSE: begin
            stop_lat_next = stop_seen;
            pos_next      = dir_reg ? (pos_reg + WIDTH'(1)) : (pos_reg - WIDTH'(1));
            gap_next      = per_r;
            state_next    = GAP;
         end

         GAP: begin
            stop_lat_next = stop_seen;
            if (gap_reg <= DIV_WIDTH'(1)) begin
               if ((pos_reg == tgt_r) || stop_seen) begin
                  done_next     = 1'b1;
                  busy_next     = 1'b0;
                  enable_next   = 1'b0;
                  stop_lat_next = 1'b0;
                  state_next    = IDLE;
               end else begin
                  nxt_next   = 1'b1;
                  state_next = PULSE;
               end
            end else begin
               gap_next = gap_reg - DIV_WIDTH'(1);
            end
         end

         default: state_next = IDLE;
      endcase
   end

   assign nxt      = nxt_reg;
   assign dir      = dir_reg;
   assign enable   = enable_reg;
   assign posicion = pos_reg;
   assign busy     = busy_reg;
   assign done     = done_reg;

endmodule

// File: tb/tb_generador_pasos.sv
// Directed bench for generador_pasos with a behavioural up/down counter attached to its outputs.
module tb_generador_pasos;

   localparam int WIDTH     = 4;
   localparam int DIV_WIDTH = 8;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 load;
   logic                 stop;
   logic [WIDTH-1:0]     target;
   logic [DIV_WIDTH-1:0] period;
   logic                 nxt, dir, enable, busy, done;
   logic [WIDTH-1:0]     posicion;
   logic [WIDTH-1:0]     cnt;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   generador_pasos #(.WIDTH(WIDTH), .DIV_WIDTH(DIV_WIDTH)) dut (
      .clk(clk), .rst(rst), .load(load), .stop(stop), .target(target), .period(period),
      .nxt(nxt), .dir(dir), .enable(enable), .posicion(posicion), .busy(busy), .done(done)
   );

   // downstream counter: one step per nxt pulse while enabled
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt <= '0;
      else if (enable && nxt) cnt <= dir ? cnt + 4'd1 : cnt - 4'd1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issue a load, then check every cycle of the move against the hand-computed schedule:
   // pulse k in cycle 2+(k-1)(1+P), done in end_cyc.
   task automatic run_move(input logic [3:0] tg, input logic [7:0] per, input int p_eff,
                           input int n_pulses, input int end_cyc, input logic exp_dir,
                           input logic [3:0] exp_pos, input int stop_cyc, input int reload_cyc);
      int  c;
      logic exp_nxt;
      @(negedge clk);
      load = 1'b1; target = tg; period = per;
      @(posedge clk); #1;
      load = 1'b0;
      for (c = 1; c <= end_cyc; c++) begin
         stop = (c == stop_cyc);
         load = (c == reload_cyc);
         if (c == reload_cyc) begin
            target = 4'd3; period = 8'd0;
         end
         @(negedge clk);
         exp_nxt = (c >= 2) && (((c - 2) % (1 + p_eff)) == 0) && (((c - 2) / (1 + p_eff)) < n_pulses);
         $display("move tgt=%0d c=%0d nxt=%0b dir=%0b busy=%0b done=%0b pos=%0d", tg, c, nxt, dir, busy, done, posicion);
         chk("nxt", {31'd0, nxt}, {31'd0, exp_nxt});
         chk("done", {31'd0, done}, {31'd0, (c == end_cyc)});
         chk("busy", {31'd0, busy}, {31'd0, (c < end_cyc) && (n_pulses > 0)});
         chk("enable", {31'd0, enable}, {31'd0, (c < end_cyc) && (n_pulses > 0)});
         if (exp_nxt) chk("dir", {31'd0, dir}, {31'd0, exp_dir});
         @(posedge clk); #1;
      end
      stop = 1'b0; load = 1'b0;
      @(negedge clk);
      chk("post_done", {31'd0, done}, 32'd0);
      chk("post_nxt", {31'd0, nxt}, 32'd0);
      chk("post_busy", {31'd0, busy}, 32'd0);
      chk("posicion", {28'd0, posicion}, {28'd0, exp_pos});
      chk("counter", {28'd0, cnt}, {28'd0, exp_pos});
   endtask

   initial begin
      rst = 1'b1; load = 1'b0; stop = 1'b0; target = '0; period = '0;
      repeat (2) @(negedge clk);
      $display("reset nxt=%0b dir=%0b enable=%0b pos=%0d busy=%0b done=%0b", nxt, dir, enable, posicion, busy, done);
      chk("rst_nxt", {31'd0, nxt}, 32'd0);
      chk("rst_dir", {31'd0, dir}, 32'd0);
      chk("rst_enable", {31'd0, enable}, 32'd0);
      chk("rst_pos", {28'd0, posicion}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      rst = 1'b0;

      // 0 -> 5, period 2: pulses 2,5,8,11,14, done 17
      run_move(4'd5, 8'd2, 2, 5, 17, 1'b1, 4'd5, 0, 0);
      // 5 -> 2, period 0 treated as 1: pulses 2,4,6, done 8
      run_move(4'd2, 8'd0, 1, 3, 8, 1'b0, 4'd2, 0, 0);
      // target equals position: done in cycle 1, no pulses, busy never set
      run_move(4'd2, 8'd3, 3, 0, 1, 1'b0, 4'd2, 0, 0);
      // back to 0
      run_move(4'd0, 8'd1, 1, 2, 6, 1'b0, 4'd0, 0, 0);
      // 0 -> 15 with an ignored reload in cycle 5: 15 pulses, done 32
      run_move(4'd15, 8'd1, 1, 15, 32, 1'b1, 4'd15, 0, 5);
      chk("full", {31'd0, (cnt == 4'd15)}, 32'd1);
      // back to 0 at period 0
      run_move(4'd0, 8'd0, 1, 15, 32, 1'b0, 4'd0, 0, 0);
      // 0 -> 10 period 1, stop in cycle 6: pulses 2,4,6, done 8, position 3
      run_move(4'd10, 8'd1, 1, 3, 8, 1'b1, 4'd3, 6, 0);

      // reset in the middle of a gap: 3 -> 9 period 4, pulse in cycle 2, gap 3..6
      @(negedge clk);
      load = 1'b1; target = 4'd9; period = 8'd4;
      @(posedge clk); #1;
      load = 1'b0;
      repeat (3) @(negedge clk);
      $display("pre-reset nxt=%0b pos=%0d busy=%0b", nxt, posicion, busy);
      chk("gap_pos", {28'd0, posicion}, 32'd4);
      #2 rst = 1'b1;
      #1;
      chk("rst_async_busy", {31'd0, busy}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         $display("in-reset cyc=%0d nxt=%0b pos=%0d", i, nxt, posicion);
         chk("rst_hold_nxt", {31'd0, nxt}, 32'd0);
      end
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         $display("after-reset cyc=%0d nxt=%0b pos=%0d busy=%0b", i, nxt, posicion, busy);
         chk("post_rst_nxt", {31'd0, nxt}, 32'd0);
         chk("post_rst_pos", {28'd0, posicion}, 32'd0);
         chk("post_rst_busy", {31'd0, busy}, 32'd0);
      end
      chk("post_rst_cnt", {28'd0, cnt}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
